// File: rtl/slave_mem_reader_if.sv
// Slave memory port seen by the reader: read/write strobes, address, size and
// the returned data with its valid flag.
interface slave_mem_reader_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int SIZE_W = 8
);
  logic              S_oe_ram;
  logic              S_we_ram;
  logic [ADDR_W-1:0] S_addr_ram;
  logic [DATA_W-1:0] S_Wdata_ram;
  logic [SIZE_W-1:0] S_data_ram_size;
  logic [DATA_W-1:0] Sout_Rdata_ram;
  logic              Sout_DataRdy;

  modport master (
    output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    input  Sout_Rdata_ram, Sout_DataRdy
  );

  modport slave (
    input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    output Sout_Rdata_ram, Sout_DataRdy
  );
endinterface

// File: rtl/slave_mem_reader.sv
// Dumps a block of words from a slave memory port onto a valid/ready stream,
// one read strobe per word, with a per-read response timeout.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | read strobe driven for one cycle
// WAIT   | waiting for Sout_DataRdy, timeout counter running
// OUT    | captured word offered on the stream
// FINISH | one-cycle done pulse
module slave_mem_reader #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 16,
  parameter int SIZE_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  slave_mem_reader_if.master  mem,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [15:0]         num_words_i,
  input  logic [SIZE_W-1:0]   word_bits_i,
  output logic [DATA_W-1:0]   out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, FINISH} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        count_q, count_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               error_q, error_d;
  logic [DATA_W-1:0]  rd_mask;
  logic [ADDR_W-1:0]  addr_step;

  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rd_mask[i] = (i < int'(size_q));
    end
  end

  assign addr_step = ADDR_W'(size_q >> 3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      size_q  <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      size_q  <= size_d;
      tmr_q   <= tmr_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    size_d  = size_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        // error_q high means this IDLE cycle carries the timeout pulse
        if (start_i && !error_q) begin
          addr_d  = base_addr_i;
          count_d = num_words_i;
          size_d  = word_bits_i;
          state_d = (num_words_i == 16'd0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        tmr_d   = TMR_W'(TIMEOUT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (mem.Sout_DataRdy) begin
          data_d  = mem.Sout_Rdata_ram & rd_mask;
          state_d = OUT;
        end else if (tmr_q == '0) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      OUT: begin
        if (out_ready_i) begin
          addr_d  = addr_q + addr_step;
          count_d = count_q - 16'd1;
          state_d = (count_q == 16'd1) ? FINISH : ISSUE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem.S_oe_ram        = (state_q == ISSUE);
  assign mem.S_addr_ram      = (state_q == ISSUE || state_q == WAIT) ? addr_q : '0;
  assign mem.S_data_ram_size = (state_q == ISSUE || state_q == WAIT) ? size_q : '0;
  assign mem.S_we_ram        = 1'b0;
  assign mem.S_Wdata_ram     = '0;

  assign out_valid_o = (state_q == OUT);
  assign out_data_o  = data_q;
  assign busy_o      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == OUT);
  assign done_o      = (state_q == FINISH);
  assign error_o     = error_q;
endmodule
